mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets a second bus master (DMA / program loader) share the ROM/RAM/output address decode with the CPU core.
- Sits between the masters and the existing address-decode/ready logic.
- Default policy: fixed priority to m0 (CPU). Starvation guard: m1 is forced through after MAX_WAIT consecutive m0 wins.

---
 rtl/mem_bus_arbiter.sv | 77 +++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (m0 fixed priority, m1 starvation-guarded) picorv32 native bus arbiter onto one slave port s_*, grant/timeout_err status; ARB_TIMEOUT_EN adds slave timeout
module mem_bus_arbiter #(
  parameter int MAX_WAIT       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic g0, g1, done, to_hit;
  if (MAX_WAIT < 1 || MAX_WAIT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("mem_bus_arbiter: parameter out of range");
  end
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_cnt <= '0;
    else if (state == IDLE) to_cnt <= '0;
    else if (!s_ready && to_cnt != 8'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 8'd1;
  assign to_hit = state != IDLE && to_cnt == 8'(TIMEOUT_CYCLES);
`else
  assign to_hit = 1'b0;
`endif
  assign timeout_err = to_hit;
  assign done = s_ready | to_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (state_nxt == GNT1 || !m1_valid)) starve_cnt <= '0;
      else if (g0 && done && m1_valid && starve_cnt != 4'(MAX_WAIT)) starve_cnt <= starve_cnt + 4'd1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = m1_valid && (!m0_valid || starve_cnt == 4'(MAX_WAIT)) ? GNT1 : m0_valid ? GNT0 : IDLE;
      GNT0:    state_nxt = done || !m0_valid ? IDLE : GNT0;
      GNT1:    state_nxt = done || !m1_valid ? IDLE : GNT1;
      default: state_nxt = IDLE;
    endcase
    grant = {g1, g0};
    s_valid = (g0 & m0_valid | g1 & m1_valid) & ~to_hit;
    s_addr = g0 ? m0_addr : g1 ? m1_addr : '0;
    s_wdata = g0 ? m0_wdata : g1 ? m1_wdata : '0;
    s_wstrb = g0 ? m0_wstrb : g1 ? m1_wstrb : '0;
    m0_ready = g0 & done;
    m1_ready = g1 & done;
    m0_rdata = !g0 ? '0 : to_hit ? 32'hDEAD_BEEF : s_rdata;
    m1_rdata = !g1 ? '0 : to_hit ? 32'hDEAD_BEEF : s_rdata;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized two-master traffic checked against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int MW = 3;
  localparam int TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_valid, m0_ready, m1_valid, m1_ready, s_valid, s_ready, timeout_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic [1:0] grant;
  logic [5:0] flags;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign flags = {grant, s_valid, m0_ready, m1_ready, timeout_err};
  mem_bus_arbiter #(.MAX_WAIT(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
  endtask
  task automatic test_reset;
    idle_in();
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    tests++;
    if (flags !== 6'b0 || {m0_rdata, m1_rdata, s_addr, s_wdata, s_wstrb} !== 100'b0) begin
      fails++; $display("FAIL reset: flags=%b data=%h, want all 0", flags, {m0_rdata, m1_rdata, s_addr});
    end
    idle_in();
    step(); rst_n = 1;
    step();
  endtask
  task automatic test_m0_read;
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 0; m0_wdata = $urandom;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL m0_read_req: flags=%b want 000000", flags); end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b011000 || s_addr !== 32'h100 || s_wstrb !== 4'h0) begin
      fails++; $display("FAIL m0_read_fwd: flags=%b addr=%h want 011000 addr 00000100", flags, s_addr);
    end
    step(); s_ready = 1; s_rdata = 32'h1234_5678;
    @(negedge clk); tests++;
    if (flags !== 6'b011100 || m0_rdata !== 32'h1234_5678 || m1_rdata !== 0) begin
      fails++; $display("FAIL m0_read_done: flags=%b rdata=%h want 011100 12345678", flags, m0_rdata);
    end
    step(); m0_valid = 0; s_ready = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL m0_read_idle: flags=%b want 000000", flags); end
  endtask
  task automatic test_both;
    step(); m0_valid = 1; m1_valid = 1; m0_addr = 32'hA0; m1_addr = 32'hA1; s_ready = 1; s_rdata = 32'h0BAD_F00D;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL both_idle: flags=%b want 000000", flags); end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b011100 || s_addr !== 32'hA0 || m1_rdata !== 0) begin
      fails++; $display("FAIL both_m0: flags=%b addr=%h want 011100 addr a0", flags, s_addr);
    end
    step(); m0_valid = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL both_bubble: flags=%b want 000000", flags); end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b101010 || s_addr !== 32'hA1 || m1_rdata !== 32'h0BAD_F00D || m0_rdata !== 0) begin
      fails++; $display("FAIL both_m1: flags=%b addr=%h rdata=%h want 101010 a1 0badf00d", flags, s_addr, m1_rdata);
    end
    step(); m1_valid = 0; s_ready = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL both_end: flags=%b want 000000", flags); end
  endtask
  task automatic test_starve;
    logic [5:0] ef;
    step(); m0_valid = 1; m1_valid = 1; s_ready = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ef = i % 2 == 0 ? 6'b000000 : i % 8 == 7 ? 6'b101010 : 6'b011100;
      tests++;
      if (flags !== ef) begin fails++; $display("FAIL starve_cyc%0d: flags=%b want %b", i, flags, ef); end
      step();
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;
  endtask
  task automatic test_m1_write;
    step(); m1_valid = 1; m1_addr = 32'h0004_0010; m1_wdata = 32'hA5A5_5A5A; m1_wstrb = 4'b0011; s_ready = 1;
    m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'hF;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL m1_write_req: flags=%b want 000000", flags); end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b101010 || {s_addr, s_wdata, s_wstrb} !== {32'h0004_0010, 32'hA5A5_5A5A, 4'b0011}) begin
      fails++; $display("FAIL m1_write_fwd: flags=%b bus=%h %h %b want 101010 00040010 a5a55a5a 0011", flags, s_addr, s_wdata, s_wstrb);
    end
    step(); m1_valid = 0; s_ready = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL m1_write_idle: flags=%b want 000000", flags); end
  endtask
  task automatic test_reset_mid;
    step(); m1_valid = 1; m1_addr = 32'h44; s_ready = 0;
    @(negedge clk);
    step(); @(negedge clk); tests++;
    if (flags !== 6'b101000) begin fails++; $display("FAIL rstmid_gnt1: flags=%b want 101000", flags); end
    step(); m0_valid = 1; m0_addr = 32'h200; rst_n = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL rstmid_reset: flags=%b want 000000", flags); end
    step(); m1_valid = 0; rst_n = 1;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL rstmid_release: flags=%b want 000000", flags); end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b011000 || s_addr !== 32'h200) begin
      fails++; $display("FAIL rstmid_m0: flags=%b addr=%h want 011000 00000200", flags, s_addr);
    end
    step(); s_ready = 1;
    @(negedge clk); tests++;
    if (flags !== 6'b011100) begin fails++; $display("FAIL rstmid_done: flags=%b want 011100", flags); end
    step(); idle_in();
  endtask
  task automatic test_timeout;
    step(); m0_valid = 1; m0_addr = 32'h300; s_ready = 0;
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      step(); @(negedge clk); tests++;
      if (flags !== 6'b011000) begin fails++; $display("FAIL timeout_stall%0d: flags=%b want 011000", k, flags); end
    end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b010101 || m0_rdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL timeout_fire: flags=%b rdata=%h want 010101 deadbeef", flags, m0_rdata);
    end
    step(); m0_valid = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL timeout_idle: flags=%b want 000000", flags); end
`else
    for (int k = 0; k < 20; k++) begin
      step(); @(negedge clk); tests++;
      if (flags !== 6'b011000) begin fails++; $display("FAIL hang_stall%0d: flags=%b want 011000", k, flags); end
    end
    step(); m0_valid = 0;
    @(negedge clk); tests++;
    if (flags !== 6'b010000) begin fails++; $display("FAIL hang_abort: flags=%b want 010000", flags); end
    step(); @(negedge clk); tests++;
    if (flags !== 6'b000000) begin fails++; $display("FAIL hang_idle: flags=%b want 000000", flags); end
`endif
  endtask
  task automatic test_random;
    int own = 0, wins = 0, stall = 0, nxt;
    bit req [2];
    logic [1:0] eg;
    logic esv;
    logic [67:0] ebus;
    req[0] = 0; req[1] = 0;
    idle_in(); step(); step();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!req[0] && $urandom_range(0, 2) == 0) begin req[0] = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom); end
      else if (req[0] && $urandom_range(0, 40) == 0) req[0] = 0;
      if (!req[1] && $urandom_range(0, 2) == 0) begin req[1] = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom); end
      else if (req[1] && $urandom_range(0, 40) == 0) req[1] = 0;
      m0_valid = req[0]; m1_valid = req[1];
      s_ready = stall >= 4 ? 1'b1 : 1'($urandom_range(0, 1));
      s_rdata = $urandom;
      @(negedge clk);
      eg = own == 1 ? 2'b01 : own == 2 ? 2'b10 : 2'b00;
      esv = own == 1 ? req[0] : own == 2 ? req[1] : 1'b0;
      ebus = own == 1 ? {m0_addr, m0_wdata, m0_wstrb} : own == 2 ? {m1_addr, m1_wdata, m1_wstrb} : 68'h0;
      tests++;
      if ({grant, s_valid} !== {eg, esv}) begin fails++; $display("FAIL rnd%0d_grant: got %b%b want %b%b", c, grant, s_valid, eg, esv); end
      tests++;
      if ({s_addr, s_wdata, s_wstrb} !== ebus) begin fails++; $display("FAIL rnd%0d_bus: got %h want %h", c, {s_addr, s_wdata, s_wstrb}, ebus); end
      tests++;
      if ({m0_ready, m0_rdata} !== {own == 1 && s_ready, own == 1 ? s_rdata : 32'h0}) begin
        fails++; $display("FAIL rnd%0d_m0: got %b %h own=%0d", c, m0_ready, m0_rdata, own);
      end
      tests++;
      if ({m1_ready, m1_rdata} !== {own == 2 && s_ready, own == 2 ? s_rdata : 32'h0}) begin
        fails++; $display("FAIL rnd%0d_m1: got %b %h own=%0d", c, m1_ready, m1_rdata, own);
      end
      tests++;
      if (timeout_err !== 1'b0) begin fails++; $display("FAIL rnd%0d_err: got %b want 0", c, timeout_err); end
      stall = own != 0 && !s_ready ? stall + 1 : 0;
      if (own == 0) begin
        nxt = req[0] && req[1] ? (wins == MW ? 2 : 1) : req[0] ? 1 : req[1] ? 2 : 0;
        if (nxt == 2 || !req[1]) wins = 0;
        own = nxt;
      end else if (s_ready) begin
        if (own == 1 && req[1]) wins = wins < MW ? wins + 1 : MW;
        req[own - 1] = 0;
        own = 0;
      end else if (!req[own - 1]) own = 0;
    end
    step(); idle_in();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle_in();
    test_reset();
    test_m0_read();
    test_both();
    test_starve();
    test_m1_write();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
